pll_lock_reset_sequencer: RTL and testbench

//  Sits directly downstream of the board PLL block. Runs on the free-running 100 MHz reference.

---
 rtl/pll_seq_pkg.sv | 14 +
 rtl/sync_bit.sv | 19 +
 rtl/pll_lock_reset_sequencer.sv | 124 ++++++++++++
 tb/tb_pll_lock_reset_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL lock / reset sequencer: FSM state encoding
// and status counter width.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  localparam int CNT8_W = 8;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level signal.
// No reset on the data path so the flops stay plain metastability filters.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_ff;

  always_ff @(posedge clk) begin
    sync_ff <= {sync_ff[STAGES-2:0], d};
  end

  assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/pll_lock_reset_sequencer.sv
// Cycles the PLL reset, qualifies lock for a stable window before releasing the
// system reset, and re-cycles the PLL on lock loss or lock timeout.
module pll_lock_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 100,
  parameter int LOCK_STABLE_CYCLES  = 10000,
  parameter int LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int SYNC_STAGES         = 2,
  parameter int CNT_W               = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              locked_i,
  input  logic              force_rst_i,
  output logic              pll_rst_o,
  output logic              sys_rst_n_o,
  output logic              ready_o,
  output logic [1:0]        state_o,
  output logic [CNT8_W-1:0] loss_cnt_o,
  output logic [CNT8_W-1:0] tmo_cnt_o
);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  function automatic logic [CNT8_W-1:0] sat_inc(input logic [CNT8_W-1:0] v);
    return (v == {CNT8_W{1'b1}}) ? v : v + CNT8_W'(1);
  endfunction

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer;
  logic             timer_clr;
  logic             tmo_inc, loss_inc;
  logic             pll_rst_nxt, run_nxt;
  logic             lock_s;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (clk),
    .d   (locked_i),
    .q   (lock_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_PLL_RST;
      timer       <= '0;
      pll_rst_o   <= 1'b1;
      sys_rst_n_o <= 1'b0;
      ready_o     <= 1'b0;
      loss_cnt_o  <= '0;
      tmo_cnt_o   <= '0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_clr ? '0 : timer + CNT_W'(1);
      pll_rst_o   <= pll_rst_nxt;
      sys_rst_n_o <= run_nxt;
      ready_o     <= run_nxt;
      if (loss_inc) loss_cnt_o <= sat_inc(loss_cnt_o);
      if (tmo_inc)  tmo_cnt_o  <= sat_inc(tmo_cnt_o);
    end
  end

  // force_rst_i wins over every other transition, including lock loss in RUN
  always_comb begin
    state_nxt = state;
    timer_clr = 1'b0;
    tmo_inc   = 1'b0;
    loss_inc  = 1'b0;
    if (force_rst_i) begin
      state_nxt = ST_PLL_RST;
      timer_clr = 1'b1;
    end else begin
      case (state)
        ST_PLL_RST: begin
          if (timer == RST_LAST) begin
            state_nxt = ST_WAIT_LOCK;
            timer_clr = 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_nxt = ST_STABLE;
            timer_clr = 1'b1;
          end else if (timer == TMO_LAST) begin
            state_nxt = ST_PLL_RST;
            timer_clr = 1'b1;
            tmo_inc   = 1'b1;
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_nxt = ST_WAIT_LOCK;
            timer_clr = 1'b1;
          end else if (timer == STABLE_LAST) begin
            state_nxt = ST_RUN;
            timer_clr = 1'b1;
          end
        end
        ST_RUN: begin
          timer_clr = 1'b1;
          if (!lock_s) begin
            state_nxt = ST_PLL_RST;
            loss_inc  = 1'b1;
          end
        end
        default: begin
          state_nxt = ST_PLL_RST;
          timer_clr = 1'b1;
        end
      endcase
    end
  end

  // Outputs decode the next state so the registered resets change on the transition edge
  always_comb begin
    pll_rst_nxt = (state_nxt == ST_PLL_RST);
    run_nxt     = (state_nxt == ST_RUN);
  end

  assign state_o = state;

endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// Scenario bench for pll_lock_reset_sequencer with short timing parameters;
// expected values are queued when stimulus is applied and popped at observation.
module tb_pll_lock_reset_sequencer;
  import pll_seq_pkg::*;

  localparam int PLL_RST_CYCLES      = 4;
  localparam int LOCK_STABLE_CYCLES  = 8;
  localparam int LOCK_TIMEOUT_CYCLES = 32;
  localparam int SYNC_STAGES         = 2;
  localparam int CNT_W               = 24;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       locked_i = 1'b0;
  logic       force_rst_i = 1'b0;
  logic       pll_rst_o, sys_rst_n_o, ready_o;
  logic [1:0] state_o;
  logic [7:0] loss_cnt_o, tmo_cnt_o;

  int          vectors = 0;
  int          miscompares = 0;
  int          model_loss = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pll_lock_reset_sequencer #(
    .PLL_RST_CYCLES      (PLL_RST_CYCLES),
    .LOCK_STABLE_CYCLES  (LOCK_STABLE_CYCLES),
    .LOCK_TIMEOUT_CYCLES (LOCK_TIMEOUT_CYCLES),
    .SYNC_STAGES         (SYNC_STAGES),
    .CNT_W               (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .locked_i    (locked_i),
    .force_rst_i (force_rst_i),
    .pll_rst_o   (pll_rst_o),
    .sys_rst_n_o (sys_rst_n_o),
    .ready_o     (ready_o),
    .state_o     (state_o),
    .loss_cnt_o  (loss_cnt_o),
    .tmo_cnt_o   (tmo_cnt_o)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] s, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (state_o == s) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
    ok = (state_o == s);
  endtask

  task automatic test_reset();
    logic [31:0] got, exp;
    rst_n = 1'b0; locked_i = 1'b0; force_rst_i = 1'b0;
    exp_q.push_back({11'd0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0});
    tick(3);
    got = {11'd0, pll_rst_o, sys_rst_n_o, ready_o, state_o, loss_cnt_o, tmo_cnt_o};
    exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want %h", got, exp);
    end
  endtask

  task automatic test_lock_release();
    logic [31:0] exp;
    int n, lat;
    rst_n = 1'b0; locked_i = 1'b0; tick(2);
    rst_n = 1'b1;
    exp_q.push_back(32'(PLL_RST_CYCLES));
    n = 0;
    while (pll_rst_o && n < 50) begin n++; tick(); end
    exp = exp_q.pop_front(); vectors++;
    if (n !== int'(exp)) begin
      miscompares++;
      $display("FAIL pll_rst_width: got %0d want %0d", n, exp);
    end
    tick(10 - n);
    locked_i = 1'b1;
    exp_q.push_back(32'(SYNC_STAGES + LOCK_STABLE_CYCLES + 1));
    lat = 0;
    while (!sys_rst_n_o && lat < 100) begin tick(); lat++; end
    exp = exp_q.pop_front(); vectors++;
    if (lat < int'(exp) - 1 || lat > int'(exp) + 1) begin
      miscompares++;
      $display("FAIL release_latency: got %0d want %0d +/-1", lat, exp);
    end
    exp_q.push_back({29'd0, 1'b1, 2'd3});
    exp = exp_q.pop_front(); vectors++;
    if ({29'd0, ready_o, state_o} !== exp) begin
      miscompares++;
      $display("FAIL run_status: ready %0d state %0d want ready 1 state 3", ready_o, state_o);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] exp;
    int  cyc, prev;
    bit  found, last, bad_sys;
    rst_n = 1'b0; locked_i = 1'b0; tick(2);
    rst_n = 1'b1;
    cyc = 0; prev = 0; bad_sys = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(32'(k));
      if (k > 1) exp_q.push_back(32'(PLL_RST_CYCLES + LOCK_TIMEOUT_CYCLES));
      last = pll_rst_o; found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
        tick(); cyc++;
        if (sys_rst_n_o) bad_sys = 1'b1;
        if (pll_rst_o && !last) found = 1'b1;
        last = pll_rst_o;
      end
      if (!found) begin
        vectors++; miscompares++;
        $display("FAIL timeout_repulse: no pll_rst_o rise within 100 cycles (pulse %0d)", k);
        exp_q.delete();
        return;
      end
      exp = exp_q.pop_front(); vectors++;
      if (tmo_cnt_o !== exp[7:0]) begin
        miscompares++;
        $display("FAIL tmo_cnt: got %0d want %0d", tmo_cnt_o, exp);
      end
      if (k > 1) begin
        exp = exp_q.pop_front(); vectors++;
        if (cyc - prev !== int'(exp)) begin
          miscompares++;
          $display("FAIL repulse_period: got %0d want %0d", cyc - prev, exp);
        end
      end
      prev = cyc;
    end
    vectors++;
    if (bad_sys !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_sys_rst: sys_rst_n_o rose got 1 want 0");
    end
  endtask

  task automatic test_glitch();
    logic [31:0] exp;
    bit ok, saw_wait, early;
    int stable_n;
    rst_n = 1'b0; locked_i = 1'b1; tick(2);
    rst_n = 1'b1;
    wait_state(ST_STABLE, 40, ok);
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL glitch_reach_stable: state %0d want 2", state_o);
      return;
    end
    tick(3);
    locked_i = 1'b0; tick();
    locked_i = 1'b1;
    exp_q.push_back(32'(LOCK_STABLE_CYCLES));
    saw_wait = 1'b0; early = 1'b0; stable_n = 0;
    for (int i = 0; i < 40 && state_o != ST_RUN; i++) begin
      tick();
      if (state_o == ST_WAIT_LOCK) saw_wait = 1'b1;
      if (saw_wait && state_o == ST_STABLE) stable_n++;
      if (state_o != ST_RUN && sys_rst_n_o) early = 1'b1;
    end
    vectors++;
    if (!saw_wait) begin
      miscompares++;
      $display("FAIL glitch_requalify: WAIT_LOCK got 0 want 1");
    end
    exp = exp_q.pop_front(); vectors++;
    if (stable_n !== int'(exp) || state_o !== ST_RUN) begin
      miscompares++;
      $display("FAIL glitch_stable_window: got %0d cycles state %0d want %0d cycles state 3", stable_n, state_o, exp);
    end
    vectors++;
    if (early) begin
      miscompares++;
      $display("FAIL glitch_early_release: got 1 want 0");
    end
    exp_q.push_back(32'd0);
    exp = exp_q.pop_front(); vectors++;
    if ({16'd0, loss_cnt_o, tmo_cnt_o} !== exp) begin
      miscompares++;
      $display("FAIL glitch_counters: loss %0d tmo %0d want 0 0", loss_cnt_o, tmo_cnt_o);
    end
  endtask

  task automatic test_loss();
    logic [31:0] exp;
    int n;
    locked_i = 1'b0;
    exp_q.push_back(32'(SYNC_STAGES + 1));
    n = 0;
    while (sys_rst_n_o && n < 20) begin tick(); n++; end
    exp = exp_q.pop_front(); vectors++;
    if (n == 0 || n > int'(exp)) begin
      miscompares++;
      $display("FAIL loss_latency: got %0d want 1..%0d", n, exp);
    end
    model_loss = 1;
    exp_q.push_back(32'(model_loss));
    exp = exp_q.pop_front(); vectors++;
    if (loss_cnt_o !== exp[7:0]) begin
      miscompares++;
      $display("FAIL loss_cnt: got %0d want %0d", loss_cnt_o, exp);
    end
    exp_q.push_back(32'(PLL_RST_CYCLES));
    n = 0;
    while (pll_rst_o && n < 50) begin n++; tick(); end
    exp = exp_q.pop_front(); vectors++;
    if (n !== int'(exp)) begin
      miscompares++;
      $display("FAIL loss_pll_rst_width: got %0d want %0d", n, exp);
    end
  endtask

  task automatic test_force_override();
    logic [31:0] exp, got;
    bit ok;
    locked_i = 1'b1;
    wait_state(ST_RUN, 60, ok);
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL force_reach_run: state %0d want 3", state_o);
      return;
    end
    locked_i = 1'b0;
    tick(SYNC_STAGES);
    exp_q.push_back(32'(ST_RUN));
    exp = exp_q.pop_front(); vectors++;
    if (state_o !== exp[1:0]) begin
      miscompares++;
      $display("FAIL force_pre_state: got %0d want %0d", state_o, exp);
    end
    force_rst_i = 1'b1;
    exp_q.push_back({20'd0, 1'b1, 1'b0, 2'd0, 8'(model_loss)});
    tick();
    force_rst_i = 1'b0;
    got = {20'd0, pll_rst_o, sys_rst_n_o, state_o, loss_cnt_o};
    exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL force_override: got %h want %h", got, exp);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] exp, got;
    bit ok;
    for (int k = 0; k < 260; k++) begin
      locked_i = 1'b1;
      wait_state(ST_RUN, 60, ok);
      if (ok) begin
        locked_i = 1'b0;
        wait_state(ST_PLL_RST, 10, ok);
      end
      if (!ok) begin
        vectors++; miscompares++;
        $display("FAIL sat_cycle: loss %0d stuck in state %0d", k, state_o);
        break;
      end
      model_loss = (model_loss < 255) ? model_loss + 1 : 255;
      exp_q.push_back(32'(model_loss));
      exp = exp_q.pop_front(); vectors++;
      if (loss_cnt_o !== exp[7:0]) begin
        miscompares++;
        $display("FAIL loss_sat: event %0d got %0d want %0d", k, loss_cnt_o, exp);
      end
    end
    locked_i = 1'b1;
    wait_state(ST_STABLE, 40, ok);
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL midstable_reach: state %0d want 2", state_o);
    end
    tick(2);
    rst_n = 1'b0;
    exp_q.push_back({11'd0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0});
    tick();
    got = {11'd0, pll_rst_o, sys_rst_n_o, ready_o, state_o, loss_cnt_o, tmo_cnt_o};
    exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL midstable_reset: got %h want %h", got, exp);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lock_release();
    test_timeout();
    test_glitch();
    test_loss();
    test_force_override();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
